instr_fetch_unit: RTL and testbench

//  Fetch sequencer that feeds the CPU's 18-bit instruction register.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_counter.sv | 27 ++
 rtl/instr_fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and widths for the CPU front end (instruction fetch path).
package cpu_pkg;

  localparam int unsigned INSTR_W_C = 18;
  localparam int unsigned ADDR_W_C  = 10;
  localparam int unsigned STALL_W_C = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2,
    HOLD  = 2'd3
  } ifu_state_t;

endpackage

// File: rtl/pc_counter.sv
// Program counter register: load has priority over increment; wraps modulo 2**ADDR_W.
module pc_counter
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_C,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              CLK,
  input  logic              clear_n,
  input  logic              ld,
  input  logic [ADDR_W-1:0] ld_val,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  // PC update: redirect beats sequential increment
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      pc <= ADDR_W'(RESET_PC);
    end else if (ld) begin
      pc <= ld_val;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch sequencer: req/ack fetch from instruction memory into the
// 18-bit instruction register, one-cycle ir_load pulse, waits for decode, handles jumps.
// Optional build macro IFU_STALL_CNT_EN adds a saturating 16-bit memory stall counter.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_C,
  parameter int unsigned INSTR_W  = INSTR_W_C,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               CLK,
  input  logic               clear_n,
  input  logic               run,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] ir_data,
  output logic               ir_load,
  input  logic               ir_ready,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [STALL_W_C-1:0] stall_cnt
`endif
);

  ifu_state_t        state_q, state_d;
  // gap: in FETCH but request withheld for one cycle after a dropped fetch
  logic              gap_q, gap_d;
  // discard: the outstanding fetch was overtaken by a jump; drop its data
  logic              discard_q, discard_d;
  logic              pc_ld, pc_inc, capture;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .CLK     (CLK),
    .clear_n (clear_n),
    .ld      (pc_ld),
    .ld_val  (jump_addr),
    .inc     (pc_inc),
    .pc      (pc)
  );

  // State and flag registers
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      state_q   <= IDLE;
      gap_q     <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      discard_q <= discard_d;
    end
  end

  // Next-state, PC control and data capture decisions
  always_comb begin
    state_d   = state_q;
    gap_d     = gap_q;
    discard_d = discard_q;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        gap_d = 1'b0;
        if (jump_valid) begin
          pc_ld = 1'b1;
        end else if (run) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (gap_q) begin
          // no transaction outstanding: a jump only moves the PC
          gap_d = 1'b0;
          pc_ld = jump_valid;
          if (!run) begin
            state_d = IDLE;
          end
        end else if (imem_ack) begin
          if (jump_valid || discard_q) begin
            // stale or overtaken word: drop it, no ir_load, refetch after a gap
            pc_ld     = jump_valid;
            discard_d = 1'b0;
            if (run) begin
              gap_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            capture = 1'b1;
            pc_inc  = 1'b1;
            state_d = LOAD;
          end
        end else if (jump_valid) begin
          pc_ld     = 1'b1;
          discard_d = 1'b1;
        end
      end
      LOAD: begin
        pc_ld   = jump_valid;
        state_d = HOLD;
      end
      HOLD: begin
        pc_ld = jump_valid;
        if (ir_ready) begin
          state_d = run ? FETCH : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request is raised in FETCH except during the post-drop gap
  assign req_d  = (state_d == FETCH) && !gap_d;
  // A new request starts from the PC value it sees after this edge
  assign addr_d = jump_valid ? jump_addr : pc;

  // Registered outputs derived from the next state
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      imem_req  <= 1'b0;
      imem_addr <= '0;
      ir_load   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      imem_req <= req_d;
      ir_load  <= (state_d == LOAD);
      busy     <= (state_d != IDLE);
      if (req_d && !imem_req) begin
        imem_addr <= addr_d;
      end
    end
  end

  // Instruction register data: captured on an accepted ack, stable otherwise
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      ir_data <= '0;
    end else if (capture) begin
      ir_data <= imem_data;
    end
  end

`ifdef IFU_STALL_CNT_EN
  // Saturating count of cycles spent waiting on memory with a request pending
  always_ff @(posedge CLK or negedge clear_n) begin
    if (!clear_n) begin
      stall_cnt <= '0;
    end else if (imem_req && !imem_ack && (stall_cnt != {STALL_W_C{1'b1}})) begin
      stall_cnt <= stall_cnt + STALL_W_C'(1);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus a randomized run
// checked against a transaction-level model of the fetched instruction stream.
module tb_instr_fetch_unit;

  localparam int unsigned AW = 10;
  localparam int unsigned IW = 18;

  logic          CLK = 1'b0;
  logic          clear_n;
  logic          run;
  logic          jump_valid;
  logic [AW-1:0] jump_addr;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_data;
  logic [IW-1:0] ir_data;
  logic          ir_load;
  logic          ir_ready;
  logic [AW-1:0] pc;
  logic          busy;
`ifdef IFU_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  instr_fetch_unit dut (
    .CLK        (CLK),
    .clear_n    (clear_n),
    .run        (run),
    .jump_valid (jump_valid),
    .jump_addr  (jump_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .ir_data    (ir_data),
    .ir_load    (ir_load),
    .ir_ready   (ir_ready),
    .pc         (pc),
    .busy       (busy)
`ifdef IFU_STALL_CNT_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory contents as a pure function of address (unique per address)
  function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
    logic [7:0] lo;
    lo = 8'(a) ^ 8'h5A;
    return {a ^ 10'h2C7, lo};
  endfunction

  task automatic test_reset();
    clear_n = 1'b0; run = 1'b0; jump_valid = 1'b0; jump_addr = '0;
    imem_ack = 1'b0; imem_data = '0; ir_ready = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
    checks++; if (ir_load !== 1'b0) begin errors++; $display("FAIL reset_ir_load got=%0b exp=0", ir_load); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL reset_pc got=%h exp=000", pc); end
    checks++; if (ir_data !== 18'h0) begin errors++; $display("FAIL reset_ir_data got=%h exp=0", ir_data); end
    checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL reset_imem_addr got=%h exp=000", imem_addr); end
  endtask

  task automatic test_basic_fetch();
    clear_n = 1'b1; run = 1'b1;
    @(negedge CLK);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t1_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL t1_addr got=%h exp=000", imem_addr); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got=%0b exp=1", busy); end
    @(negedge CLK);
    checks++; if (ir_load !== 1'b0) begin errors++; $display("FAIL t1_early_load got=%0b exp=0", ir_load); end
    imem_ack = 1'b1; imem_data = 18'h2AAAA;
    @(negedge CLK);
    imem_ack = 1'b0; imem_data = '0;
    checks++; if (ir_load !== 1'b1) begin errors++; $display("FAIL t1_load got=%0b exp=1", ir_load); end
    checks++; if (ir_data !== 18'h2AAAA) begin errors++; $display("FAIL t1_ir_data got=%h exp=2aaaa", ir_data); end
    checks++; if (pc !== 10'h001) begin errors++; $display("FAIL t1_pc got=%h exp=001", pc); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t1_req_drop got=%0b exp=0", imem_req); end
    @(negedge CLK);
    checks++; if (ir_load !== 1'b0) begin errors++; $display("FAIL t1_load_pulse got=%0b exp=0", ir_load); end
  endtask

  task automatic test_hold_wait();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t2_req_hold%0d got=%0b exp=0", i, imem_req); end
      checks++; if (ir_data !== 18'h2AAAA) begin errors++; $display("FAIL t2_data_hold%0d got=%h exp=2aaaa", i, ir_data); end
    end
    ir_ready = 1'b1;
    @(negedge CLK);
    ir_ready = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t2_req got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 10'h001) begin errors++; $display("FAIL t2_addr got=%h exp=001", imem_addr); end
  endtask

  task automatic test_jump_in_fetch();
    jump_valid = 1'b1; jump_addr = 10'h3F0;
    @(negedge CLK);
    jump_valid = 1'b0;
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t3_req_held got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 10'h001) begin errors++; $display("FAIL t3_addr_stable got=%h exp=001", imem_addr); end
    checks++; if (pc !== 10'h3F0) begin errors++; $display("FAIL t3_pc got=%h exp=3f0", pc); end
    imem_ack = 1'b1; imem_data = 18'h3C3C3;
    @(negedge CLK);
    imem_ack = 1'b0;
    checks++; if (ir_load !== 1'b0) begin errors++; $display("FAIL t3_no_load got=%0b exp=0", ir_load); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t3_gap got=%0b exp=0", imem_req); end
    @(negedge CLK);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t3_refetch got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 10'h3F0) begin errors++; $display("FAIL t3_refetch_addr got=%h exp=3f0", imem_addr); end
    checks++; if (ir_data !== 18'h2AAAA) begin errors++; $display("FAIL t3_data_kept got=%h exp=2aaaa", ir_data); end
    imem_ack = 1'b1; imem_data = 18'h12345;
    @(negedge CLK);
    imem_ack = 1'b0;
    checks++; if (ir_load !== 1'b1) begin errors++; $display("FAIL t3_load got=%0b exp=1", ir_load); end
    checks++; if (ir_data !== 18'h12345) begin errors++; $display("FAIL t3_ir_data got=%h exp=12345", ir_data); end
    checks++; if (pc !== 10'h3F1) begin errors++; $display("FAIL t3_pc_inc got=%h exp=3f1", pc); end
  endtask

  task automatic test_wrap_and_jump_ack();
    // jump while in LOAD; decode ready so the next fetch uses the jump target
    jump_valid = 1'b1; jump_addr = 10'h3FF; ir_ready = 1'b1;
    @(negedge CLK);
    jump_valid = 1'b0;
    checks++; if (pc !== 10'h3FF) begin errors++; $display("FAIL t4_pc_jump got=%h exp=3ff", pc); end
    @(negedge CLK);
    ir_ready = 1'b0;
    checks++; if (imem_addr !== 10'h3FF) begin errors++; $display("FAIL t4_addr got=%h exp=3ff", imem_addr); end
    imem_ack = 1'b1; imem_data = 18'h0ABCD;
    @(negedge CLK);
    imem_ack = 1'b0;
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL t4_pc_wrap got=%h exp=000", pc); end
    checks++; if (ir_data !== 18'h0ABCD) begin errors++; $display("FAIL t4_ir_data got=%h exp=0abcd", ir_data); end
    ir_ready = 1'b1;
    repeat (2) @(negedge CLK);
    ir_ready = 1'b0;
    checks++; if (imem_addr !== 10'h000) begin errors++; $display("FAIL t4_wrap_addr got=%h exp=000", imem_addr); end
    jump_valid = 1'b1; jump_addr = 10'h155; imem_ack = 1'b1; imem_data = 18'h3FFFF;
    @(negedge CLK);
    jump_valid = 1'b0; imem_ack = 1'b0;
    checks++; if (ir_load !== 1'b0) begin errors++; $display("FAIL t4_dropped_load got=%0b exp=0", ir_load); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t4_req_gap got=%0b exp=0", imem_req); end
    checks++; if (pc !== 10'h155) begin errors++; $display("FAIL t4_pc got=%h exp=155", pc); end
    checks++; if (ir_data !== 18'h0ABCD) begin errors++; $display("FAIL t4_data_kept got=%h exp=0abcd", ir_data); end
    @(negedge CLK);
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL t4_refetch got=%0b exp=1", imem_req); end
    checks++; if (imem_addr !== 10'h155) begin errors++; $display("FAIL t4_refetch_addr got=%h exp=155", imem_addr); end
  endtask

  task automatic test_reset_mid_fetch();
    #2 clear_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t5_req got=%0b exp=0", imem_req); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_busy got=%0b exp=0", busy); end
    checks++; if (pc !== 10'h000) begin errors++; $display("FAIL t5_pc got=%h exp=000", pc); end
    checks++; if (ir_data !== 18'h0) begin errors++; $display("FAIL t5_ir_data got=%h exp=0", ir_data); end
    run = 1'b0; imem_ack = 1'b1; imem_data = 18'h2FFFF;
    @(negedge CLK);
    clear_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (ir_load !== 1'b0) begin errors++; $display("FAIL t5_stray_load%0d got=%0b exp=0", i, ir_load); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle%0d got=%0b exp=0", i, busy); end
    end
    imem_ack = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [AW-1:0] exp_addr;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] held;
    logic [IW-1:0] last_data;
    logic          req_seen;
    logic          prev_load;
    int            lat;
    int            loads;
    exp_addr = 10'h000; last_data = '0; req_seen = 1'b0; prev_load = 1'b0; lat = 0; loads = 0;
    run = 1'b1;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge CLK);
      // memory responder with random latency
      if (imem_ack) begin
        imem_ack = 1'b0; req_seen = 1'b0;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rnd_req_after_ack cyc=%0d got=%0b exp=0", cyc, imem_req); end
      end else if (imem_req) begin
        if (!req_seen) begin
          req_seen = 1'b1; held = imem_addr; lat = int'($urandom_range(0, 3));
        end else begin
          checks++; if (imem_addr !== held) begin errors++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, imem_addr, held); end
        end
        if (lat == 0) begin
          imem_ack = 1'b1; imem_data = memf(imem_addr);
        end else begin
          lat--;
        end
      end
      // stream model: loaded words follow the program order, jumps redirect it
      if (ir_load) begin
        exp_pc = exp_addr + 10'd1;
        checks++; if (ir_data !== memf(exp_addr)) begin errors++; $display("FAIL rnd_ir_data cyc=%0d got=%h exp=%h", cyc, ir_data, memf(exp_addr)); end
        checks++; if (pc !== exp_pc) begin errors++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", cyc, pc, exp_pc); end
        checks++; if (prev_load !== 1'b0) begin errors++; $display("FAIL rnd_load_pulse cyc=%0d got=%0b exp=0", cyc, prev_load); end
        last_data = memf(exp_addr);
        exp_addr = exp_pc;
        loads++;
      end else begin
        checks++; if (ir_data !== last_data) begin errors++; $display("FAIL rnd_data_stable cyc=%0d got=%h exp=%h", cyc, ir_data, last_data); end
      end
      prev_load = ir_load;
      // stimulus for the next edge
      ir_ready = ($urandom_range(0, 2) == 0);
      jump_valid = ($urandom_range(0, 11) == 0);
      if (jump_valid) begin
        if ($urandom_range(0, 2) == 0) jump_addr = AW'(10'h3FC + AW'($urandom_range(0, 3)));
        else jump_addr = AW'($urandom);
        exp_addr = jump_addr;
      end
    end
    jump_valid = 1'b0; imem_ack = 1'b0; run = 1'b0;
    checks++; if (loads < 20) begin errors++; $display("FAIL rnd_load_count got=%0d exp>=20", loads); end
  endtask

`ifdef IFU_STALL_CNT_EN
  task automatic test_stall_cnt();
    clear_n = 1'b0; run = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0; jump_valid = 1'b0;
    @(negedge CLK);
    clear_n = 1'b1; run = 1'b1;
    @(negedge CLK);
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL t6_stall_start got=%0d exp=0", stall_cnt); end
    repeat (7) @(negedge CLK);
    imem_ack = 1'b1; imem_data = 18'h11111;
    @(negedge CLK);
    imem_ack = 1'b0;
    checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL t6_stall_cnt got=%0d exp=7", stall_cnt); end
    repeat (3) @(negedge CLK);
    checks++; if (stall_cnt !== 16'd7) begin errors++; $display("FAIL t6_stall_hold got=%0d exp=7", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_fetch();
    test_hold_wait();
    test_jump_in_fetch();
    test_wrap_and_jump_ack();
    test_reset_mid_fetch();
    test_random_stream();
`ifdef IFU_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
